thresh_frame_sink: RTL

Receiving end of the thresholded pixel stream. Accepts one binarised pixel per cycle on a write-enable strobe, stores the frame raster-order in an internal buffer and accumulates the foreground mass count. Sits downstream of the threshold/equalisation pipeline's `we`/`dataEncoded`/`finallydone` outputs and presents the finished frame plus statistics to the host side.

---
 rtl/thresh_frame_sink.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/thresh_frame_sink.sv
// Frame sink for the thresholded pixel stream: raster-order buffer, mass/pixel counts, status.
// Optional `THRESH_SINK_CENTROID_EN adds foreground column/row index sums on sum_x / sum_y.
module thresh_frame_sink #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 13
`ifdef THRESH_SINK_CENTROID_EN
  ,
  parameter int unsigned SUM_W  = $clog2(IMG_W * IMG_H * IMG_W)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [7:0]        din,
  input  logic              finallydone,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [CNT_W-1:0]  mass_count,
  output logic [CNT_W-1:0]  pix_count,
  output logic              done,
  output logic              frame_valid,
  output logic              short_frame,
  output logic              bad_pix,
`ifdef THRESH_SINK_CENTROID_EN
  output logic [SUM_W-1:0]  sum_x,
  output logic [SUM_W-1:0]  sum_y,
`endif
  output logic              overrun
);

  localparam int unsigned NPix  = IMG_W * IMG_H;
  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] mass_q, mass_d;
  logic             fv_q, fv_d;
  logic             short_q, short_d;
  logic             bad_q, bad_d;
  logic             over_q, over_d;
  logic [7:0]       rd_q;

  logic             capture;
  logic             last_pix;
  logic             din_bad;

  // A pixel is accepted in IDLE or COLLECT; clear always wins over a coincident strobe.
  assign capture  = we && !clear && (state_q != StDone);
  assign last_pix = (pix_q == CNT_W'(NPix - 1));
  assign din_bad  = (din != 8'h00) && (din != 8'hFF);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    mass_d  = mass_q;
    fv_d    = 1'b0;
    short_d = short_q;
    bad_d   = bad_q;
    over_d  = over_q;

    if (clear) begin
      state_d = StIdle;
      pix_d   = '0;
      mass_d  = '0;
      short_d = 1'b0;
      bad_d   = 1'b0;
      over_d  = 1'b0;
    end else begin
      if (capture) begin
        pix_d = pix_q + CNT_W'(1);
        if (din[7]) begin
          mass_d = mass_q + CNT_W'(1);
        end
        if (din_bad) begin
          bad_d = 1'b1;
        end
      end

      case (state_q)
        StIdle: begin
          // finallydone is ignored here: no frame has started yet.
          if (we) begin
            if (last_pix) begin
              state_d = StDone;
              short_d = 1'b0;
              fv_d    = 1'b1;
            end else begin
              state_d = StCollect;
            end
          end
        end
        StCollect: begin
          if (we && last_pix) begin
            state_d = StDone;
            short_d = 1'b0;
            fv_d    = 1'b1;
          end else if (finallydone) begin
            state_d = StDone;
            short_d = 1'b1;
            fv_d    = 1'b1;
          end
        end
        StDone: begin
          if (we) begin
            over_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pix_q   <= '0;
      mass_q  <= '0;
      fv_q    <= 1'b0;
      short_q <= 1'b0;
      bad_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      mass_q  <= mass_d;
      fv_q    <= fv_d;
      short_q <= short_d;
      bad_q   <= bad_d;
      over_q  <= over_d;
    end
  end

  // Frame buffer: one write port, one registered read port; no reset so it maps to RAM.
  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[ADDR_W'(pix_q)] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 8'h00;
    end else begin
      rd_q <= mem_q[rd_addr];
    end
  end

`ifdef THRESH_SINK_CENTROID_EN
  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [SUM_W-1:0] sx_q, sx_d;
  logic [SUM_W-1:0] sy_q, sy_d;

  // Column/row track the raster position of the pixel about to be captured.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
      sx_d  = '0;
      sy_d  = '0;
    end else if (capture) begin
      if (din[7]) begin
        sx_d = sx_q + SUM_W'(col_q);
        sy_d = sy_q + SUM_W'(row_q);
      end
      if (col_q == ColW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

  assign sum_x = sx_q;
  assign sum_y = sy_q;
`endif

  assign rd_data     = rd_q;
  assign mass_count  = mass_q;
  assign pix_count   = pix_q;
  assign done        = (state_q == StDone);
  assign frame_valid = fv_q;
  assign short_frame = short_q;
  assign bad_pix     = bad_q;
  assign overrun     = over_q;

endmodule
